// File: rtl/axis_lfsr_source.sv
// ---------------------------------------------------------------------------
// axis_lfsr_source
//
// AXI4-Stream pseudo-random frame generator. Each frame carries frame_len
// beats of a 32-bit Galois LFSR sequence (x^32+x^22+x^2+x+1). A frame starts
// when start is seen in IDLE with a non-zero length. In continuous mode,
// frames repeat back-to-back until stop is requested. The next frame
// continues the LFSR sequence without reseeding.
//
// Parameters
//   DEFAULT_SEED  seed used when the sampled seed is zero
//   LEN_WIDTH     width of frame_len and of the beat counter
//
// Ports
//   aclk            clock, rising edge
//   aresetn         asynchronous active-low reset
//   start           level-sampled frame request (honoured only in IDLE)
//   stop            end continuous mode after the current frame
//   continuous      1: frames repeat back-to-back
//   seed            LFSR seed, sampled on an accepted start
//   frame_len       beats per frame, sampled on an accepted start
//   m_axis_tdata    stream data (current LFSR state)
//   m_axis_tvalid   stream valid
//   m_axis_tlast    last beat of a frame
//   m_axis_tready   downstream ready
//   busy            high whenever not IDLE
//   frame_count     completed frames, wrapping at 2^16
// ---------------------------------------------------------------------------
module axis_lfsr_source #(
  parameter logic [31:0] DEFAULT_SEED = 32'h0000_0001,
  parameter int          LEN_WIDTH    = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [31:0]          seed,
  input  logic [LEN_WIDTH-1:0] frame_len,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic                 busy,
  output logic [15:0]          frame_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  state_t                 state_q, state_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   stop_pending_q, stop_pending_d;
  logic [31:0]            tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   busy_q, busy_d;
  logic [15:0]            frame_count_q, frame_count_d;

  logic [31:0]            lfsr_adv;
  logic [31:0]            seed_eff;
  logic [LEN_WIDTH-1:0]   beat_inc;
  logic                   handshake;
  logic                   end_run;

  // Galois step; a non-zero state never maps to zero, so seeding with a
  // non-zero value keeps the register out of the lock-up state.
  assign lfsr_adv  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  assign seed_eff  = (seed == 32'h0) ? DEFAULT_SEED : seed;
  assign beat_inc  = beat_q + LEN_WIDTH'(1);
  assign handshake = tvalid_q & m_axis_tready;
  // A stop arriving on the very cycle of the tlast handshake also ends the run.
  assign end_run   = ~continuous | stop_pending_q | stop;

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    beat_d         = beat_q;
    len_d          = len_q;
    stop_pending_d = stop_pending_q;
    tdata_d        = tdata_q;
    tvalid_d       = tvalid_q;
    tlast_d        = tlast_q;
    frame_count_d  = frame_count_q;

    unique case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          state_d        = RUN;
          len_d          = frame_len;
          beat_d         = '0;
          lfsr_d         = seed_eff;
          tdata_d        = seed_eff;
          tvalid_d       = 1'b1;
          tlast_d        = (frame_len == LEN_WIDTH'(1));
          stop_pending_d = 1'b0;
        end
      end

      RUN: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end
        if (handshake) begin
          lfsr_d = lfsr_adv;
          if (tlast_q) begin
            frame_count_d = frame_count_q + 16'd1;
            beat_d        = '0;
            if (end_run) begin
              state_d        = IDLE;
              tvalid_d       = 1'b0;
              tlast_d        = 1'b0;
              stop_pending_d = 1'b0;
            end else begin
              // Next frame follows immediately with the same latched length.
              tdata_d = lfsr_adv;
              tlast_d = (len_q == LEN_WIDTH'(1));
            end
          end else begin
            beat_d  = beat_inc;
            tdata_d = lfsr_adv;
            tlast_d = (beat_inc == (len_q - LEN_WIDTH'(1)));
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      lfsr_q         <= DEFAULT_SEED;
      beat_q         <= '0;
      len_q          <= '0;
      stop_pending_q <= 1'b0;
      tdata_q        <= 32'h0;
      tvalid_q       <= 1'b0;
      tlast_q        <= 1'b0;
      busy_q         <= 1'b0;
      frame_count_q  <= 16'h0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      beat_q         <= beat_d;
      len_q          <= len_d;
      stop_pending_q <= stop_pending_d;
      tdata_q        <= tdata_d;
      tvalid_q       <= tvalid_d;
      tlast_q        <= tlast_d;
      busy_q         <= busy_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_axis_lfsr_source.sv
// ---------------------------------------------------------------------------
// tb_axis_lfsr_source
//
// Self-checking bench for axis_lfsr_source. Expected beats are pushed into a
// scoreboard queue when a frame is launched and popped as the DUT hands
// them over. Outputs are sampled and inputs driven on the falling edge.
// ---------------------------------------------------------------------------
module tb_axis_lfsr_source;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [31:0] seed;
  logic [15:0] frame_len;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;
  logic [15:0] frame_count;

  beat_t       exp_q[$];
  logic [15:0] exp_fc;
  int          n_checks;
  int          n_pass;

  axis_lfsr_source dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .stop          (stop),
    .continuous    (continuous),
    .seed          (seed),
    .frame_len     (frame_len),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Reference LFSR step: x^32+x^22+x^2+x+1, Galois form.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Queue the beats of nframes consecutive frames (LFSR continues across frames).
  task automatic push_frames(input logic [31:0] s0, input int len, input int nframes);
    logic [31:0] s;
    beat_t b;
    s = (s0 == 32'h0) ? 32'h0000_0001 : s0;
    for (int f = 0; f < nframes; f++) begin
      for (int k = 0; k < len; k++) begin
        b.data = s;
        b.last = (k == len - 1);
        exp_q.push_back(b);
        s = lfsr_next(s);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_fc = 16'h0;
    @(negedge aclk);
  endtask

  // Present a start request for exactly one rising edge; returns on the
  // falling edge after it, where the first beat must already be visible.
  task automatic start_frame(input logic [31:0] s, input logic [15:0] len, input logic cont);
    seed       = s;
    frame_len  = len;
    continuous = cont;
    start      = 1'b1;
    @(negedge aclk);
    start      = 1'b0;
  endtask

  // Consume the scoreboard. Checks every handshake and that an un-accepted
  // beat is held stable. Optionally pulses stop while beat stop_beat is offered.
  task automatic drain(input bit rand_ready, input int stop_beat, output int cycles);
    int          budget;
    int          beat;
    logic        pv, pr, pl;
    logic [31:0] pd;
    beat_t       e;
    budget = 0;
    beat   = 0;
    pv     = 1'b0;
    pr     = 1'b0;
    pl     = 1'b0;
    pd     = 32'h0;
    cycles = 0;
    while (exp_q.size() > 0 && budget < 2000) begin
      if (pv && !pr) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl)
          $display("FAIL hold: valid=%0b data=%08h last=%0b, required valid=1 data=%08h last=%0b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, pd, pl);
        else
          n_pass++;
      end
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stop = (stop_beat != 0) && (beat + 1 == stop_beat) && m_axis_tvalid;
      if (m_axis_tvalid && m_axis_tready) begin
        e = exp_q.pop_front();
        beat++;
        $display("beat %0d data=%08h last=%0b (expected %08h/%0b)",
                 beat, m_axis_tdata, m_axis_tlast, e.data, e.last);
        n_checks++;
        if (m_axis_tdata !== e.data)
          $display("FAIL beat%0d_data: got %08h, required %08h", beat, m_axis_tdata, e.data);
        else
          n_pass++;
        n_checks++;
        if (m_axis_tlast !== e.last)
          $display("FAIL beat%0d_last: got %0b, required %0b", beat, m_axis_tlast, e.last);
        else
          n_pass++;
        if (e.last) exp_fc = exp_fc + 16'd1;
      end
      pv = m_axis_tvalid;
      pr = m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
      @(negedge aclk);
      budget++;
      cycles++;
    end
    stop = 1'b0;
    m_axis_tready = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end else begin
      n_pass++;
    end
  endtask

  // Frame just ended: tvalid and busy must already be low, count must match.
  task automatic check_idle(input string tag);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_idle: valid=%0b busy=%0b, required 0/0", tag, m_axis_tvalid, busy);
    else
      n_pass++;
    n_checks++;
    if (frame_count !== exp_fc)
      $display("FAIL %s_frame_count: got %0d, required %0d", tag, frame_count, exp_fc);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'h0 ||
        busy !== 1'b0 || frame_count !== 16'h0)
      $display("FAIL reset_state: valid=%0b last=%0b data=%08h busy=%0b fc=%0d, required all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, frame_count);
    else
      n_pass++;
    aresetn = 1'b1;
    exp_fc  = 16'h0;
    @(negedge aclk);
    @(negedge aclk);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_wait_start: valid=%0b busy=%0b, required 0/0", m_axis_tvalid, busy);
    else
      n_pass++;
  endtask

  task automatic test_basic();
    int cyc;
    beat_t b;
    b.data = 32'h0000_0001; b.last = 1'b0; exp_q.push_back(b);
    b.data = 32'h8020_0003; b.last = 1'b0; exp_q.push_back(b);
    b.data = 32'hC030_0002; b.last = 1'b1; exp_q.push_back(b);
    m_axis_tready = 1'b1;
    start_frame(32'h1, 16'd3, 1'b0);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || busy !== 1'b1)
      $display("FAIL basic_latency: valid=%0b busy=%0b one cycle after start, required 1/1",
               m_axis_tvalid, busy);
    else
      n_pass++;
    drain(1'b0, 0, cyc);
    n_checks++;
    if (cyc != 3)
      $display("FAIL basic_cycles: took %0d cycles, required 3", cyc);
    else
      n_pass++;
    check_idle("basic");
  endtask

  task automatic test_backpressure();
    int cyc;
    push_frames(32'h1, 3, 1);
    m_axis_tready = 1'b0;
    start_frame(32'h1, 16'd3, 1'b0);
    drain(1'b1, 0, cyc);
    check_idle("backpressure");
  endtask

  task automatic test_zero();
    int cyc;
    start_frame(32'h1234_5678, 16'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0)
        $display("FAIL zero_len: valid=%0b busy=%0b, required 0/0", m_axis_tvalid, busy);
      else
        n_pass++;
      @(negedge aclk);
    end
    push_frames(32'h0, 1, 1);
    start_frame(32'h0, 16'd1, 1'b0);
    drain(1'b0, 0, cyc);
    check_idle("zero_seed");
  endtask

  task automatic test_reset_midframe();
    int cyc;
    m_axis_tready = 1'b1;
    start_frame(32'h1, 16'd4, 1'b0);
    @(negedge aclk);
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h8020_0003)
      $display("FAIL midreset_beat2: valid=%0b data=%08h, required 1/80200003",
               m_axis_tvalid, m_axis_tdata);
    else
      n_pass++;
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0 || frame_count !== 16'h0)
      $display("FAIL midreset_async: valid=%0b last=%0b busy=%0b fc=%0d, required 0/0/0/0",
               m_axis_tvalid, m_axis_tlast, busy, frame_count);
    else
      n_pass++;
    exp_fc = 16'h0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    push_frames(32'h1, 2, 1);
    start_frame(32'h1, 16'd2, 1'b0);
    drain(1'b0, 0, cyc);
    check_idle("midreset_replay");
  endtask

  task automatic test_continuous();
    int cyc;
    apply_reset();
    push_frames(32'h1, 2, 3);
    m_axis_tready = 1'b1;
    start_frame(32'h1, 16'd2, 1'b1);
    drain(1'b0, 5, cyc);
    continuous = 1'b0;
    n_checks++;
    if (cyc != 6)
      $display("FAIL cont_no_bubble: 6 beats took %0d cycles, required 6", cyc);
    else
      n_pass++;
    check_idle("continuous");
    n_checks++;
    if (frame_count !== 16'd3)
      $display("FAIL cont_frames: got %0d, required 3", frame_count);
    else
      n_pass++;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    exp_fc        = 16'h0;
    aresetn       = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    continuous    = 1'b0;
    seed          = 32'h0;
    frame_len     = 16'h0;
    m_axis_tready = 1'b0;

    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_reset_midframe();
    test_continuous();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
